uart_tx_periph: RTL and testbench
=================================

// Module: uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter; bus responder to the CPU load/store port (rd/wr/addr/wdata/rdata).
//  Software writes bytes to TXD; block buffers them in a small FIFO, serialises 8N1 frames on UART_TX, raises tx_irq.
//  Sits beside the peripheral decoder; rdata is muxed into the CPU load path when addr[30]=1.
// PARAMETERS
//  CLK_FREQ    100_000_000  sysclk frequency, Hz
//  BAUD        9600         line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer, >=2)
//  FIFO_DEPTH  4            TX byte buffer depth, power of 2, >=2
//  BASE_ADDR   32'h40000018 TXD address; CON = BASE_ADDR+8
// PORTS
//  sysclk   in   1   clock, all state on rising edge
//  reset    in   1   asynchronous, active-low
//  rd       in   1   bus read strobe
//  wr       in   1   bus write strobe (one cycle per store)
//  addr     in   32  byte address
//  wdata    in   32  write data
//  rdata    out  32  read data, combinational
//  UART_TX  out  1   serial line, idle high
//  tx_irq   out  1   level interrupt = done & irq_en
// BEHAVIOUR
//  Reset (async, reset=0): UART_TX=1, FIFO empty, state IDLE, baud cnt=0, irq_en=0, done=0, ovf=0, tx_irq=0.
//  Register map:
//   TXD (BASE_ADDR) W: push wdata[7:0]. R: 32'h0.
//   CON (BASE_ADDR+8) R: {26'b0, full, busy, ovf, done, 1'b0, irq_en} at bits [5:0].
//     W: bit0 -> irq_en; bit2=1 clears done; bit3=1 clears ovf; other bits ignored.
//  rdata = 0 when rd=0 or addr matches neither register. No side effects on read.
//  busy = (state!=IDLE) | ~fifo_empty.
//  Push: wr & addr==TXD at edge N. Accepted if !full, or full with pop at same edge; else byte dropped, ovf<=1.
//  FSM (one bit-time = DIV clocks, counted by baud cnt 0..DIV-1):
//   IDLE : UART_TX=1; if FIFO non-empty -> pop head into shift reg, go START, cnt=0.
//   START: UART_TX=0 for DIV clocks -> DATA, bit idx=0.
//   DATA : UART_TX=shift[0], LSB first; each DIV clocks shift right, idx++; after idx 7 -> STOP.
//   STOP : UART_TX=1 for DIV clocks; at end set done<=1; pop next byte if present (START directly, no idle gap) else IDLE.
//  Latency: byte pushed at edge N into empty FIFO with FSM IDLE -> pop at edge N+1, UART_TX=0 after edge N+1.
//  Frame = 10*DIV clocks; back-to-back bytes give continuous frames.
//  UART_TX driven from a register (glitch-free).
//  Simultaneous: done set by STOP and CON write bit2=1 same edge -> set wins.
//   ovf set and clear same edge -> set wins.
//  Writes to CON never affect FIFO or FSM; frame in progress unaffected by irq_en changes.
//  Reset mid-frame: line returns to 1 immediately, partial byte and FIFO contents discarded.
//  FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = ptrs differ only in MSB.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE/START/DATA/STOP, 2 bits), CON bit positions,
//   default TXD/CON address constants.
//  Sub-module tx_fifo (sync FIFO, 8-bit wide, push/pop/full/empty/head); FSM, baud counter,
//   register decode stay in uart_tx_periph.
// TESTING  (bench uses CLK_FREQ=16, BAUD=1 -> DIV=16)
//  1 Reset: assert reset=0 mid-operation -> UART_TX=1, rdata(CON)=0, tx_irq=0 on same cycle.
//  2 Write TXD=8'hA5 -> UART_TX low one clock after write edge; line 0,1,0,1,0,0,1,0,1,1 each 16 clks;
//    done=1 at frame end (160 clks), CON reads 32'h04.
//  3 irq_en=1 then send 8'h00 -> tx_irq rises at stop end; write CON=32'h05 -> tx_irq falls next cycle.
//  4 Push 5 bytes 8'h01..8'h05 back-to-back while idle -> first pops, 4 buffered, none dropped, ovf=0;
//    6th write while full -> dropped, CON bit3 ovf=1; 5 contiguous frames, 800 clks, no idle gap.
//  5 Read TXD and unmapped addr 32'h40000010 with rd=1 -> rdata=0; rd=0 on CON -> rdata=0.
//  6 CON write bit2=1 on the same edge STOP completes -> done remains 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// control/status bit positions and default register addresses.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int CON_IRQ_EN = 0;
    localparam int CON_DONE   = 2;
    localparam int CON_OVF    = 3;
    localparam int CON_BUSY   = 4;
    localparam int CON_FULL   = 5;

    localparam logic [31:0] TXD_ADDR_DEFAULT = 32'h4000_0018;
    localparam logic [31:0] CON_OFFSET       = 32'h0000_0008;

    function automatic logic [31:0] con_word(input logic full, input logic busy,
                                             input logic ovf, input logic done,
                                             input logic irq_en);
        logic [31:0] w;
        w             = '0;
        w[CON_FULL]   = full;
        w[CON_BUSY]   = busy;
        w[CON_OVF]    = ovf;
        w[CON_DONE]   = done;
        w[CON_IRQ_EN] = irq_en;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// CPU load/store port as seen by the UART transmitter; the CPU side is the
// master, the peripheral answers reads combinationally on rdata.
interface uart_tx_periph_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the serialiser. Head is read combinationally so the FSM can
// load a byte on the same edge it pops it.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    // Extra MSB distinguishes full from empty when the index bits coincide.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXD/CON register decode, byte FIFO,
// baud-timed serialiser FSM and a level interrupt on frame completion.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = TXD_ADDR_DEFAULT
) (
    input  logic             sysclk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             UART_TX,
    output logic             tx_irq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [31:0]   CON_ADDR = BASE_ADDR + CON_OFFSET;

    tx_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        tx_reg, tx_next;
    logic        done_reg, ovf_reg, irq_en_reg;

    logic        pop, done_set, bit_end;
    logic        fifo_full, fifo_empty, fifo_push;
    logic [7:0]  fifo_head;
    logic        txd_wr, con_wr, push_drop, busy;
    logic        unused_wdata;

    assign txd_wr    = bus.wr && (bus.addr == BASE_ADDR);
    assign con_wr    = bus.wr && (bus.addr == CON_ADDR);
    // A full FIFO still takes the byte when the serialiser frees a slot on this edge.
    assign fifo_push = txd_wr && (!fifo_full || pop);
    assign push_drop = txd_wr && fifo_full && !pop;
    assign busy      = (state_reg != ST_IDLE) || !fifo_empty;
    assign bit_end   = (cnt_reg == CNT_LAST);
    assign unused_wdata = ^{bus.wdata[31:8], bus.wdata[7:4], bus.wdata[1]};

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.wdata[7:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && (bus.addr == CON_ADDR))
            bus.rdata = con_word(fifo_full, busy, ovf_reg, done_reg, irq_en_reg);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;
        done_set   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    cnt_next   = '0;
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                        tx_next  = shift_reg[1];
                    end
                end
            end
            ST_STOP: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (bit_end) begin
                    cnt_next = '0;
                    done_set = 1'b1;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // Status set events take priority over software clears on the same edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            done_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            irq_en_reg <= 1'b0;
        end else begin
            if (con_wr) irq_en_reg <= bus.wdata[CON_IRQ_EN];
            if (done_set)
                done_reg <= 1'b1;
            else if (con_wr && bus.wdata[CON_DONE])
                done_reg <= 1'b0;
            if (push_drop)
                ovf_reg <= 1'b1;
            else if (con_wr && bus.wdata[CON_OVF])
                ovf_reg <= 1'b0;
        end
    end

    assign UART_TX = tx_reg;
    assign tx_irq  = done_reg && irq_en_reg;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scenario bench for uart_tx_periph at DIV=16: expected frames are queued when
// bytes are written and compared as the line is decoded.
`timescale 1ns/1ps
module tb_uart_tx_periph;
    import uart_pkg::*;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    logic UART_TX;
    logic tx_irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [9:0] exp_q [$];

    uart_tx_periph_if bus ();

    uart_tx_periph #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (TXD)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .bus     (bus),
        .UART_TX (UART_TX),
        .tx_irq  (tx_irq)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required <100000", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(posedge sysclk);
        #1;
        bus.wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        d        = bus.rdata;
        bus.rd   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back({1'b1, b, 1'b0});
        bus_write(TXD, {24'h0, b});
    endtask

    // Waits (bounded) for a start bit, then samples mid-bit; returns after the stop-bit sample.
    task automatic rx_frame(output logic [9:0] bits, output int det, output bit timed_out);
        timed_out = 1'b1;
        bits      = '1;
        det       = 0;
        for (int i = 0; i < 400; i++) begin
            if (UART_TX === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            step(1);
        end
        if (!timed_out) begin
            det = cyc;
            step(8);
            bits[0] = UART_TX;
            for (int b = 1; b < 10; b++) begin
                step(16);
                bits[b] = UART_TX;
            end
            $display("rx frame bits=%b start_cyc=%0d", bits, det);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lows;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b0;
        step(3);
        checks++;
        if (UART_TX !== 1'b1) begin failures++; $display("FAIL reset_line got=%b want=1", UART_TX); end
        checks++;
        if (tx_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", tx_irq); end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_con got=%h want=0", d); end
        reset = 1'b1;
        step(2);
        bus_write(CON, 32'h1);
        bus_write(TXD, 32'h0);
        step(170);
        checks++;
        if (tx_irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b want=1", tx_irq); end
        bus_write(TXD, 32'h0);
        bus_write(TXD, 32'h55);
        step(60);
        checks++;
        if (UART_TX !== 1'b0) begin failures++; $display("FAIL mid_frame_line got=%b want=0", UART_TX); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (UART_TX !== 1'b1) begin failures++; $display("FAIL async_reset_line got=%b want=1", UART_TX); end
        checks++;
        if (tx_irq !== 1'b0) begin failures++; $display("FAIL async_reset_irq got=%b want=0", tx_irq); end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL async_reset_con got=%h want=0", d); end
        @(posedge sysclk);
        #1 reset = 1'b1;
        lows = 0;
        repeat (200) begin
            step(1);
            if (UART_TX !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL post_reset_quiet low_cycles=%0d want=0", lows); end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL post_reset_con got=%h want=0", d); end
        $display("reset scenario done");
    endtask

    task automatic test_basic_frame();
        logic [31:0] d;
        logic [9:0]  bits, exp;
        int t0, det;
        bit to;
        send_byte(8'hA5);
        t0 = cyc;
        checks++;
        if (UART_TX !== 1'b1) begin failures++; $display("FAIL a5_pre_start got=%b want=1", UART_TX); end
        rx_frame(bits, det, to);
        checks++;
        if (to || exp_q.size() == 0) begin
            failures++; $display("FAIL a5_frame timeout=%0d queued=%0d want frame", to, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            if (bits !== exp) begin failures++; $display("FAIL a5_frame got=%b want=%b", bits, exp); end
        end
        checks++;
        if (det - t0 != 1) begin failures++; $display("FAIL a5_start_latency got=%0d want=1", det - t0); end
        step(7);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h10) begin failures++; $display("FAIL a5_con_before_end got=%h want=10", d); end
        step(1);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h04) begin failures++; $display("FAIL a5_con_done got=%h want=04", d); end
    endtask

    task automatic test_reads();
        logic [31:0] d;
        bus_read(TXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL read_txd got=%h want=0", d); end
        bus_read(32'h4000_0010, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL read_unmapped got=%h want=0", d); end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h04) begin failures++; $display("FAIL read_con got=%h want=04", d); end
        bus.addr = CON;
        bus.rd   = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 32'h0) begin failures++; $display("FAIL read_no_strobe got=%h want=0", bus.rdata); end
        $display("read scenario done");
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [9:0]  bits, exp;
        int det;
        bit to;
        bus_write(CON, 32'h0D);
        checks++;
        if (tx_irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b want=0", tx_irq); end
        send_byte(8'h00);
        rx_frame(bits, det, to);
        checks++;
        if (to || exp_q.size() == 0) begin
            failures++; $display("FAIL irq_frame timeout=%0d queued=%0d want frame", to, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            if (bits !== exp) begin failures++; $display("FAIL irq_frame got=%b want=%b", bits, exp); end
        end
        step(7);
        checks++;
        if (tx_irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b want=0", tx_irq); end
        step(1);
        checks++;
        if (tx_irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b want=1", tx_irq); end
        bus_write(CON, 32'h05);
        checks++;
        if (tx_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", tx_irq); end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h01) begin failures++; $display("FAIL irq_con got=%h want=01", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [9:0]  bits, exp;
        int t0, det;
        bit to, found;
        bus_write(CON, 32'h0C);
        t0 = 0;
        for (int k = 1; k <= 5; k++) begin
            send_byte(8'(k));
            if (k == 1) t0 = cyc;
        end
        bus_read(CON, d);
        checks++;
        if (d !== 32'h30) begin failures++; $display("FAIL b2b_full got=%h want=30", d); end
        bus_write(TXD, 32'h06);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h38) begin failures++; $display("FAIL b2b_ovf got=%h want=38", d); end
        for (int k = 0; k < 5; k++) begin
            rx_frame(bits, det, to);
            checks++;
            if (to || exp_q.size() == 0) begin
                failures++; $display("FAIL b2b_frame%0d timeout=%0d queued=%0d want frame", k, to, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                if (bits !== exp) begin failures++; $display("FAIL b2b_frame%0d got=%b want=%b", k, bits, exp); end
            end
            if (k > 0) begin
                checks++;
                if (det - t0 != 1 + 160 * k) begin
                    failures++; $display("FAIL b2b_start%0d got=%0d want=%0d", k, det - t0, 1 + 160 * k);
                end
            end
        end
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus_read(CON, d);
            if (d[CON_BUSY] === 1'b0) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!found || cyc - t0 != 801) begin
            failures++; $display("FAIL b2b_span found=%0d got=%0d want=801", found, cyc - t0);
        end
        checks++;
        if (d !== 32'h0C) begin failures++; $display("FAIL b2b_end_con got=%h want=0c", d); end
        bus_write(CON, 32'h08);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h04) begin failures++; $display("FAIL b2b_ovf_clear got=%h want=04", d); end
    endtask

    task automatic test_done_race();
        logic [31:0] d;
        logic [9:0]  bits, exp;
        int det;
        bit to;
        bus_write(CON, 32'h0C);
        send_byte(8'h3C);
        rx_frame(bits, det, to);
        checks++;
        if (to || exp_q.size() == 0) begin
            failures++; $display("FAIL race_frame timeout=%0d queued=%0d want frame", to, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            if (bits !== exp) begin failures++; $display("FAIL race_frame got=%b want=%b", bits, exp); end
        end
        step(7);
        bus_write(CON, 32'h04);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h04) begin failures++; $display("FAIL race_done_set_wins got=%h want=04", d); end
        bus_write(CON, 32'h04);
        bus_read(CON, d);
        checks++;
        if (d !== 32'h00) begin failures++; $display("FAIL race_done_clear got=%h want=00", d); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_reads();
        test_irq();
        test_back_to_back();
        test_done_race();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
